// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch time counter: default field moduli,
// field widths and the lap/hold state encoding.
package stopwatch_pkg;

    localparam int TENTH_MOD_DEF = 10;
    localparam int SEC_MOD_DEF   = 60;
    localparam int MIN_MOD_DEF   = 60;
    localparam int HOUR_MOD_DEF  = 24;

    localparam int TENTH_W = $clog2(TENTH_MOD_DEF);
    localparam int SEC_W   = $clog2(SEC_MOD_DEF);
    localparam int MIN_W   = $clog2(MIN_MOD_DEF);
    localparam int HOUR_W  = $clog2(HOUR_MOD_DEF);

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } hold_state_e;

endpackage

// File: rtl/stopwatch_time_counter_mod_counter.sv
// Modulo-MOD counter stage; carry is asserted combinationally on the increment
// that wraps, so a chain of stages resolves its ripple within one clock edge.
module mod_counter #(
    parameter int MOD = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc,
    input  logic                   clr,
    output logic [$clog2(MOD)-1:0] value,
    output logic                   carry
);

    localparam int W = $clog2(MOD);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         at_max;

    assign at_max = (value_q == W'(MOD - 1));
    assign carry  = inc && at_max;
    assign value  = value_q;

    // NOTE: default the next-state first so every path assigns it and no latch is inferred.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = at_max ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Cascaded stopwatch time (tenths/sec/min/hour) with lap hold, display mux and
// a registered rollover pulse at the 23:59:59.9 -> 00:00:00.0 wrap.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int TENTH_MOD = TENTH_MOD_DEF,
    parameter int SEC_MOD   = SEC_MOD_DEF,
    parameter int MIN_MOD   = MIN_MOD_DEF,
    parameter int HOUR_MOD  = HOUR_MOD_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         clear,
    input  logic                         lap,
    output logic                         hold,
    output logic [$clog2(TENTH_MOD)-1:0] disp_tenth,
    output logic [$clog2(SEC_MOD)-1:0]   disp_sec,
    output logic [$clog2(MIN_MOD)-1:0]   disp_min,
    output logic [$clog2(HOUR_MOD)-1:0]  disp_hour,
    output logic [$clog2(SEC_MOD)-1:0]   live_sec,
    output logic                         rollover
);

    localparam int TW = $clog2(TENTH_MOD);
    localparam int SW = $clog2(SEC_MOD);
    localparam int MW = $clog2(MIN_MOD);
    localparam int HW = $clog2(HOUR_MOD);

    logic [TW-1:0] live_tenth;
    logic [SW-1:0] live_sec_w;
    logic [MW-1:0] live_min;
    logic [HW-1:0] live_hour;
    logic          c_tenth, c_sec, c_min, c_hour;
    logic          advance;

    hold_state_e   state_q;
    logic [TW-1:0] lap_tenth_q;
    logic [SW-1:0] lap_sec_q;
    logic [MW-1:0] lap_min_q;
    logic [HW-1:0] lap_hour_q;
    logic          rollover_q;

    // A tick coincident with clear is discarded, so it never enters the chain.
    assign advance = tick && !clear;

    mod_counter #(.MOD(TENTH_MOD)) u_tenth (
        .clk(clk), .reset(reset), .inc(advance), .clr(clear),
        .value(live_tenth), .carry(c_tenth)
    );
    mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk(clk), .reset(reset), .inc(c_tenth), .clr(clear),
        .value(live_sec_w), .carry(c_sec)
    );
    mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk(clk), .reset(reset), .inc(c_sec), .clr(clear),
        .value(live_min), .carry(c_min)
    );
    mod_counter #(.MOD(HOUR_MOD)) u_hour (
        .clk(clk), .reset(reset), .inc(c_min), .clr(clear),
        .value(live_hour), .carry(c_hour)
    );

    // NOTE: sequential state uses non-blocking assignments only, so lap capture sees pre-tick values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LIVE;
            lap_tenth_q <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_hour_q  <= '0;
            rollover_q  <= 1'b0;
        end else if (clear) begin
            state_q     <= LIVE;
            lap_tenth_q <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_hour_q  <= '0;
            rollover_q  <= 1'b0;
        end else begin
            rollover_q <= c_hour;
            if (lap) begin
                if (state_q == LIVE) begin
                    state_q     <= FROZEN;
                    lap_tenth_q <= live_tenth;
                    lap_sec_q   <= live_sec_w;
                    lap_min_q   <= live_min;
                    lap_hour_q  <= live_hour;
                end else begin
                    state_q <= LIVE;
                end
            end
        end
    end

    assign hold       = (state_q == FROZEN);
    assign disp_tenth = hold ? lap_tenth_q : live_tenth;
    assign disp_sec   = hold ? lap_sec_q   : live_sec_w;
    assign disp_min   = hold ? lap_min_q   : live_min;
    assign disp_hour  = hold ? lap_hour_q  : live_hour;
    assign live_sec   = live_sec_w;
    assign rollover   = rollover_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Self-checking bench: a time-in-tenths reference model feeds a scoreboard,
// with a vector table and hand-written sequences for lap, clear, reset and wrap.
module tb_stopwatch_time_counter;

    localparam int DAY = 10 * 60 * 60 * 24;
    localparam int S_TM = 2, S_SM = 3, S_MM = 3, S_HM = 2;
    localparam int S_DAY = S_TM * S_SM * S_MM * S_HM;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0, clear = 1'b0, lap = 1'b0;
    logic       hold, rollover;
    logic [3:0] disp_tenth;
    logic [5:0] disp_sec, disp_min, live_sec;
    logic [4:0] disp_hour;

    logic       s_tick = 1'b0;
    logic       s_clear = 1'b0, s_lap = 1'b0;
    logic       s_hold, s_roll;
    logic [0:0] s_dt, s_dh;
    logic [1:0] s_ds, s_dm, s_ls;

    always #5 clk = ~clk;

    stopwatch_time_counter dut (
        .clk(clk), .reset(reset), .tick(tick), .clear(clear), .lap(lap),
        .hold(hold), .disp_tenth(disp_tenth), .disp_sec(disp_sec),
        .disp_min(disp_min), .disp_hour(disp_hour), .live_sec(live_sec),
        .rollover(rollover)
    );

    stopwatch_time_counter #(
        .TENTH_MOD(S_TM), .SEC_MOD(S_SM), .MIN_MOD(S_MM), .HOUR_MOD(S_HM)
    ) dut_small (
        .clk(clk), .reset(reset), .tick(s_tick), .clear(s_clear), .lap(s_lap),
        .hold(s_hold), .disp_tenth(s_dt), .disp_sec(s_ds),
        .disp_min(s_dm), .disp_hour(s_dh), .live_sec(s_ls),
        .rollover(s_roll)
    );

    typedef struct packed {
        logic       hold;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [3:0] tenth;
        logic [5:0] live_sec;
        logic       roll;
    } obs_t;

    typedef struct {
        logic       tick;
        logic [3:0] exp_tenth;
        logic [5:0] exp_sec;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    obs_t sb_q[$];

    int   m_t = 0;
    int   m_lap = 0;
    bit   m_hold = 1'b0;
    bit   m_roll = 1'b0;

    function automatic obs_t model_obs();
        obs_t o;
        int   shown;
        shown      = m_hold ? m_lap : m_t;
        o.hold     = m_hold;
        o.tenth    = 4'(shown % 10);
        o.sec      = 6'((shown / 10) % 60);
        o.min      = 6'((shown / 600) % 60);
        o.hour     = 5'((shown / 36000) % 24);
        o.live_sec = 6'((m_t / 10) % 60);
        o.roll     = m_roll;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.hold     = hold;
        o.tenth    = disp_tenth;
        o.sec      = disp_sec;
        o.min      = disp_min;
        o.hour     = disp_hour;
        o.live_sec = live_sec;
        o.roll     = rollover;
        return o;
    endfunction

    task automatic model_reset();
        m_t = 0; m_lap = 0; m_hold = 1'b0; m_roll = 1'b0;
    endtask

    task automatic model_step(input bit tk, input bit cl, input bit lp);
        if (cl) begin
            model_reset();
        end else begin
            m_roll = tk && (m_t == DAY - 1);
            if (lp) begin
                if (!m_hold) begin
                    m_lap  = m_t;
                    m_hold = 1'b1;
                end else begin
                    m_hold = 1'b0;
                end
            end
            if (tk) m_t = (m_t + 1) % DAY;
        end
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got hold=%0d %0d:%0d:%0d.%0d live_sec=%0d roll=%0d, want hold=%0d %0d:%0d:%0d.%0d live_sec=%0d roll=%0d",
                     name, act.hold, act.hour, act.min, act.sec, act.tenth, act.live_sec, act.roll,
                     exp.hold, exp.hour, exp.min, exp.sec, exp.tenth, exp.live_sec, exp.roll);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus: model predicts, scoreboard holds it until the edge.
    task automatic drive(input bit tk, input bit cl, input bit lp, input string name);
        @(negedge clk);
        tick = tk; clear = cl; lap = lp;
        model_step(tk, cl, lp);
        sb_q.push_back(model_obs());
        @(posedge clk);
        #1;
        tick = 1'b0; clear = 1'b0; lap = 1'b0;
        if (sb_q.size() == 0) begin
            check_val({name, " scoreboard_empty"}, 0, 1);
        end else begin
            check(name, dut_obs(), sb_q.pop_front());
        end
    endtask

    task automatic run_ticks(input int n, input string name);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, name);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        obs_t zero_obs;
        int   st;
        logic [6:0] s_exp;

        for (int i = 0; i < 10; i++) begin
            tbl[i].tick      = 1'b1;
            tbl[i].exp_tenth = 4'((i + 1) % 10);
            tbl[i].exp_sec   = (i == 9) ? 6'd1 : 6'd0;
        end
        zero_obs = '0;

        // Reset state
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", dut_obs(), zero_obs);
        @(negedge clk) reset = 1'b1;
        model_reset();

        // Full wrap on a small-modulus instance: rollover exactly one cycle
        st = 0;
        for (int i = 0; i < S_DAY + 2; i++) begin
            @(negedge clk) s_tick = (i < S_DAY);
            @(posedge clk);
            #1;
            if (s_tick) st = (st + 1) % S_DAY;
            s_exp = {1'((st / (S_TM * S_SM * S_MM)) % S_HM), 2'((st / (S_TM * S_SM)) % S_MM),
                     2'((st / S_TM) % S_SM), 1'(st % S_TM), (i == S_DAY - 1)};
            s_tick = 1'b0;
            vectors++;
            if ({s_dh, s_dm, s_ds, s_dt, s_roll} !== s_exp) begin
                miscompares++;
                $display("FAIL small_wrap[%0d]: got %b want %b", i, {s_dh, s_dm, s_ds, s_dt, s_roll}, s_exp);
            end
        end

        // Table: 10 ticks spaced 5 clocks apart
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].tick, 1'b0, 1'b0, "tbl_tick");
            repeat (4) drive(1'b0, 1'b0, 1'b0, "tbl_idle");
            check_val($sformatf("tbl_tenth[%0d]", i), int'(disp_tenth), int'(tbl[i].exp_tenth));
            check_val($sformatf("tbl_sec[%0d]", i), int'(disp_sec), int'(tbl[i].exp_sec));
            check_val($sformatf("tbl_roll[%0d]", i), int'(rollover), 0);
        end

        // Carry sec -> min on a single edge
        drive(1'b0, 1'b1, 1'b0, "clear");
        run_ticks(599, "to_59_9");
        check_val("pre_carry_sec", int'(disp_sec), 59);
        drive(1'b1, 1'b0, 1'b0, "carry_tick");
        check_val("carry_min", int'(disp_min), 1);
        check_val("carry_sec", int'(disp_sec), 0);
        check_val("carry_tenth", int'(disp_tenth), 0);

        // Lap coincident with tick captures pre-increment value
        drive(1'b0, 1'b1, 1'b0, "clear");
        run_ticks(34, "to_3_4");
        drive(1'b1, 1'b0, 1'b1, "lap_tick");
        check_val("lap_hold", int'(hold), 1);
        check_val("lap_disp", int'(disp_sec) * 10 + int'(disp_tenth), 34);
        run_ticks(20, "frozen_ticks");
        check_val("frozen_disp", int'(disp_sec) * 10 + int'(disp_tenth), 34);
        check_val("frozen_live_sec", int'(live_sec), 5);
        drive(1'b0, 1'b0, 1'b1, "lap_release");
        check_val("release_hold", int'(hold), 0);
        check_val("release_disp", int'(disp_sec) * 10 + int'(disp_tenth), 55);

        // Clear wins over coincident tick and lap while frozen
        drive(1'b0, 1'b1, 1'b0, "clear");
        run_ticks(623, "to_1_02_3");
        drive(1'b0, 1'b0, 1'b1, "freeze");
        check_val("freeze_min", int'(disp_min), 1);
        drive(1'b1, 1'b1, 1'b1, "clear_all");
        check("clear_all_zero", dut_obs(), zero_obs);

        // Async reset mid-cycle
        run_ticks(77, "to_7_7");
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check("async_reset", dut_obs(), zero_obs);
        model_reset();
        @(negedge clk) reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, "post_reset_tick");
        check_val("post_reset_tenth", int'(disp_tenth), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
- Downstream consumer of the 10 Hz tick divider; turns each 1-cycle tick into a cascaded stopwatch time: tenths, seconds, minutes, hours.
- Provides a lap/hold function: the display freezes on a captured time while live counting continues.
- Outputs feed the FND/display formatting stage. Run/stop is handled upstream by gating the divider enable.

Parameters:
- TENTH_MOD, 10, modulus of tenths field (0..9)
- SEC_MOD, 60, modulus of seconds field (0..59)
- MIN_MOD, 60, modulus of minutes field (0..59)
- HOUR_MOD, 24, modulus of hours field (0..23)

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- tick  in  1  1-cycle pulse from the 10 Hz divider; advances time by 0.1 s
- clear  in  1  synchronous clear of all counters and lap state; level, sampled each cycle
- lap  in  1  1-cycle pulse (debounced, edge-detected upstream); toggles hold mode
- hold  out  1  1 = display frozen on lap value
- disp_tenth  out  4  displayed tenths
- disp_sec  out  6  displayed seconds
- disp_min  out  6  displayed minutes
- disp_hour  out  5  displayed hours
- live_sec  out  6  live seconds, never frozen, for other consumers
- rollover  out  1  registered 1-cycle pulse when time wraps from 23:59:59.9 to 00:00:00.0

Behaviour:
- Reset (reset=0, async): all live fields, lap registers, hold and rollover = 0. Display therefore reads 00:00:00.0.
- All state updates on posedge clk. Outputs are registered or a pure mux of registers; no combinational path from inputs to outputs.
- Tick handling (clear=0, tick=1):
  - tenth increments.
  - When tenth == TENTH_MOD-1, it wraps to 0 and carries to sec.
  - sec wraps at SEC_MOD-1 and carries to min; min carries to hour; hour wraps at HOUR_MOD-1.
  - The whole carry chain resolves in the same edge (0-cycle ripple). Latency tick to live field is 1 clk.
- tick=0: all live fields hold.
- rollover = 1 for exactly the cycle after the edge where all four fields wrap simultaneously; 0 otherwise.
- Lap state machine, states LIVE (hold=0) and FROZEN (hold=1):
  - LIVE + lap=1: capture current live values (pre-increment if tick is coincident) into lap registers and go to FROZEN.
  - FROZEN + lap=1: go to LIVE; lap registers are unchanged but unused.
  - Display mux: disp_* = hold ? lap_* : live_*.
- clear=1 (priority over tick and lap):
  - all live fields and lap registers = 0, hold = 0, rollover = 0.
  - A coincident tick is discarded; a coincident lap is ignored.
- Field widths use $clog2(MOD). No field ever exceeds MOD-1. Out-of-range values cannot be produced; no saturation logic.
- Reset asserted mid-count: immediate async clear. Counting resumes from 0 on the first tick after release.

Decomposition:
- Shared package stopwatch_pkg:
  - default moduli constants
  - field width localparams (TENTH_W=4, SEC_W=6, MIN_W=6, HOUR_W=5)
  - hold state encoding LIVE=1'b0, FROZEN=1'b1
- One reusable sub-module, mod_counter: parameterised MOD; inputs inc and clr; outputs value and carry (= inc && value==MOD-1). Instantiate four times and chain each carry into the next stage's inc.
- The top level adds lap registers, the hold FSM, the display mux and the rollover register.

Test Plan:
- Reset, then 10 ticks spaced 5 clk apart: live and display reach 00:00:01.0; tenth reads 0..9 then wraps to 0; rollover stays 0.
- Preload by ticking to 00:00:59.9, then 1 tick: fields read sec=0, min=1, tenth=0, all on the same edge.
- Run to 23:59:59.9, then 1 tick: all fields 0; rollover high exactly 1 cycle, then 0.
- At 00:00:03.4, lap pulse coincident with tick: hold=1 and display reads 00:00:03.4 while live_sec advances. After 20 further ticks, a second lap gives hold=0 and display 00:00:05.5.
- In FROZEN at 00:01:02.3, assert clear coincident with tick and lap: next cycle all displays 0, hold=0, live 0, rollover 0.
- Assert reset asynchronously mid-clock while at 00:00:07.7: outputs 0 before the next edge; after release, the first tick gives tenth=1.
